alu_sequencer: RTL and testbench

//  Command front-end for the 16-bit structural alu. Accepts one operation per

---
 rtl/alu_seq_pkg.sv | 16 +
 rtl/alu_sequencer_if.sv | 18 +
 rtl/alu_sequencer_alu.sv | 30 +++
 rtl/alu_sequencer.sv | 83 ++++++++
 tb/tb_alu_sequencer.sv | 143 ++++++++++++++
 5 files changed

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared states, opcodes and flag bit positions for the alu sequencer
package alu_seq_pkg;
  typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_t;
  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_NOT = 4'b0101;
  localparam logic [3:0] OP_CLR = 4'b0110;
  localparam logic [3:0] OP_MUL = 4'b1000;
  localparam int F_C = 3;
  localparam int F_V = 2;
  localparam int F_N = 1;
  localparam int F_Z = 0;
endpackage

// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: command and response handshake bundle of the alu sequencer
interface alu_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [15:0] cmd_a;
  logic [15:0] cmd_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_lo;
  logic [15:0] rsp_hi;
  logic [3:0]  rsp_flags;
  logic        rsp_err;
  modport master (output cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
                  input cmd_ready, rsp_valid, rsp_lo, rsp_hi, rsp_flags, rsp_err);
  modport slave (input cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
                 output cmd_ready, rsp_valid, rsp_lo, rsp_hi, rsp_flags, rsp_err);
endinterface

// File: rtl/alu_sequencer_alu.sv
// alu: 16-bit combinational alu with {C,V,N,Z}; C,V,N only meaningful for ADD/SUB
module alu (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [2:0]  op,
  output logic [15:0] s,
  output logic        c,
  output logic        v,
  output logic        n,
  output logic        z
);
  logic [16:0] sum, dif;
  logic        arith;
  assign sum = {1'b0, a} + {1'b0, b};
  assign dif = {1'b0, a} - {1'b0, b};
  always_comb begin
    s = op == 3'b000 ? sum[15:0] :
        op == 3'b001 ? dif[15:0] :
        op == 3'b010 ? a & b :
        op == 3'b011 ? a | b :
        op == 3'b100 ? a ^ b :
        op == 3'b101 ? ~a : '0;
    arith = op[2:1] == 2'b00;
    // dif[16] is the borrow, so SUB reports C=1 when a<b
    c = arith & (op[0] ? dif[16] : sum[16]);
    v = arith & (op[0] ? (a[15] ^ b[15]) & (s[15] ^ a[15]) : ~(a[15] ^ b[15]) & (s[15] ^ a[15]));
    n = arith & s[15];
    z = ~|s;
  end
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: handshake front-end for the alu, adding a 16-cycle shift-add multiply
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter bit MUL_EN = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  alu_sequencer_if.slave bus,
  output logic busy
);
  state_t      state, state_n;
  logic [3:0]  op_q, cnt, flags_q;
  logic [15:0] a_q, b_q, hi_q, lo_q, hi_n, lo_n;
  logic [15:0] alu_a, alu_b, s;
  logic [2:0]  alu_op;
  logic        err_q, illegal, is_mul, c, v, n, z;
  assign is_mul  = MUL_EN && bus.cmd_op == OP_MUL;
  assign illegal = op_q[3] && !(MUL_EN && op_q == OP_MUL);
  always_comb begin
    alu_a  = state == MUL ? hi_q : a_q;
    alu_b  = state == MUL ? (lo_q[0] ? a_q : '0) : b_q;
    alu_op = state == MUL ? OP_ADD[2:0] : op_q[2:0];
    hi_n   = {c, s[15:1]};
    lo_n   = {s[0], lo_q[15:1]};
  end
  alu u_alu (.a(alu_a), .b(alu_b), .op(alu_op), .s(s), .c(c), .v(v), .n(n), .z(z));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = bus.cmd_valid ? (is_mul ? MUL : EXEC) : IDLE;
      EXEC: state_n = DONE;
      MUL:  state_n = cnt == 4'd15 ? DONE : MUL;
      DONE: state_n = bus.rsp_ready ? IDLE : DONE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt     <= '0;
      flags_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.cmd_valid) begin
          op_q  <= bus.cmd_op;
          a_q   <= bus.cmd_a;
          b_q   <= bus.cmd_b;
          hi_q  <= '0;
          lo_q  <= bus.cmd_b;
          cnt   <= '0;
          err_q <= 1'b0;
        end
        EXEC: begin
          hi_q    <= '0;
          lo_q    <= illegal ? '0 : s;
          flags_q <= illegal ? '0 : {c, v, n, z};
          err_q   <= illegal;
        end
        MUL: begin
          hi_q <= hi_n;
          lo_q <= lo_n;
          cnt  <= cnt + 4'd1;
          if (cnt == 4'd15) flags_q <= {|hi_n, 2'b00, ~|{hi_n, lo_n}};
        end
        DONE: ;
      endcase
    end
  assign bus.cmd_ready = state == IDLE;
  assign bus.rsp_valid = state == DONE;
  assign bus.rsp_lo    = lo_q;
  assign bus.rsp_hi    = hi_q;
  assign bus.rsp_flags = flags_q;
  assign bus.rsp_err   = err_q;
  assign busy          = state != IDLE;
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed vectors with a response scoreboard for alu_sequencer
module tb_alu_sequencer;
  typedef struct {
    logic [15:0] lo;
    logic [15:0] hi;
    logic [3:0]  f;
    logic        e;
    string       nm;
  } rsp_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic busy, busy2;
  int checks = 0, errors = 0;
  rsp_t q[$], q2[$];
  alu_sequencer_if bus();
  alu_sequencer_if bus2();
  alu_sequencer #(.MUL_EN(1'b1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy));
  alu_sequencer #(.MUL_EN(1'b0)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2), .busy(busy2));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic mon(input rsp_t r, input logic [15:0] lo, hi, input logic [3:0] f, input logic e);
    chk({r.nm, " lo"}, {16'h0, lo}, {16'h0, r.lo});
    chk({r.nm, " hi"}, {16'h0, hi}, {16'h0, r.hi});
    chk({r.nm, " flags"}, {28'h0, f}, {28'h0, r.f});
    chk({r.nm, " err"}, {31'h0, e}, {31'h0, r.e});
  endtask
  always @(negedge clk)
    if (bus.rsp_valid && bus.rsp_ready) begin
      if (q.size() == 0) chk("unexpected response", 1, 0);
      else mon(q.pop_front(), bus.rsp_lo, bus.rsp_hi, bus.rsp_flags, bus.rsp_err);
    end
  always @(negedge clk)
    if (bus2.rsp_valid && bus2.rsp_ready) begin
      if (q2.size() == 0) chk("unexpected response dut2", 1, 0);
      else mon(q2.pop_front(), bus2.rsp_lo, bus2.rsp_hi, bus2.rsp_flags, bus2.rsp_err);
    end
  task automatic issue(input logic [3:0] op, input logic [15:0] a, b);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op = op;
    bus.cmd_a = a;
    bus.cmd_b = b;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
  endtask
  task automatic wait_idle(input string nm);
    int n = 0;
    while (!bus.cmd_ready && n < 40) begin
      @(posedge clk);
      #1 n++;
    end
    if (n >= 40) chk({nm, " idle timeout"}, 1, 0);
  endtask
  task automatic send(input string nm, input logic [3:0] op, input logic [15:0] a, b,
                      input logic [15:0] lo, hi, input logic [3:0] f, input logic e, input int lat);
    int n = 0;
    q.push_back('{lo, hi, f, e, nm});
    issue(op, a, b);
    while (!bus.rsp_valid && n < 40) begin
      @(posedge clk);
      #1 n++;
    end
    chk({nm, " latency"}, n, lat);
    wait_idle(nm);
  endtask
  initial begin
    int n;
    bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_a = '0; bus.cmd_b = '0; bus.rsp_ready = 1'b1;
    bus2.cmd_valid = 1'b0; bus2.cmd_op = '0; bus2.cmd_a = '0; bus2.cmd_b = '0; bus2.rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk("reset cmd_ready", {31'h0, bus.cmd_ready}, 1);
    chk("reset rsp_valid", {31'h0, bus.rsp_valid}, 0);
    chk("reset busy", {31'h0, busy}, 0);
    chk("reset outputs", {bus.rsp_hi, bus.rsp_lo}, 0);
    @(negedge clk) rst_n = 1'b1;
    send("add ovf", 4'b0000, 16'h7FFF, 16'h0001, 16'h8000, 16'h0, 4'b0110, 1'b0, 1);
    send("add carry", 4'b0000, 16'hFFFF, 16'h0001, 16'h0000, 16'h0, 4'b1001, 1'b0, 1);
    send("sub zero", 4'b0001, 16'h0005, 16'h0005, 16'h0000, 16'h0, 4'b0001, 1'b0, 1);
    send("sub borrow", 4'b0001, 16'h0003, 16'h0005, 16'hFFFE, 16'h0, 4'b1010, 1'b0, 1);
    send("and", 4'b0010, 16'hF0F0, 16'h0FF0, 16'h00F0, 16'h0, 4'b0000, 1'b0, 1);
    send("or", 4'b0011, 16'h1200, 16'h0034, 16'h1234, 16'h0, 4'b0000, 1'b0, 1);
    send("xor", 4'b0100, 16'hAAAA, 16'hAAAA, 16'h0000, 16'h0, 4'b0001, 1'b0, 1);
    send("not", 4'b0101, 16'h00FF, 16'h0000, 16'hFF00, 16'h0, 4'b0000, 1'b0, 1);
    send("clr", 4'b0110, 16'h1234, 16'h5678, 16'h0000, 16'h0, 4'b0001, 1'b0, 1);
    send("clr7", 4'b0111, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0, 4'b0001, 1'b0, 1);
    send("mul max", 4'b1000, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 4'b1000, 1'b0, 16);
    send("mul zero", 4'b1000, 16'h0000, 16'h1234, 16'h0000, 16'h0000, 4'b0001, 1'b0, 16);
    send("mul small", 4'b1000, 16'h0003, 16'h0005, 16'h000F, 16'h0000, 4'b0000, 1'b0, 16);
    send("mul mid", 4'b1000, 16'h1234, 16'h0100, 16'h3400, 16'h0012, 4'b1000, 1'b0, 16);
    send("illegal", 4'b1011, 16'h1234, 16'h5678, 16'h0000, 16'h0000, 4'b0000, 1'b1, 1);
    bus.rsp_ready = 1'b0;
    q.push_back('{16'h3333, 16'h0, 4'b0000, 1'b0, "backpressure"});
    issue(4'b0000, 16'h1111, 16'h2222);
    n = 0;
    while (!bus.rsp_valid && n < 40) begin
      @(posedge clk);
      #1 n++;
    end
    chk("bp latency", n, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.cmd_valid = 1'b1; bus.cmd_op = 4'b0000; bus.cmd_a = 16'h0001; bus.cmd_b = 16'h0001;
      @(posedge clk);
      #1 chk("bp rsp_valid", {31'h0, bus.rsp_valid}, 1);
      chk("bp cmd_ready", {31'h0, bus.cmd_ready}, 0);
      chk("bp rsp stable", {bus.rsp_hi, bus.rsp_lo}, 32'h0000_3333);
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    wait_idle("backpressure");
    issue(4'b1000, 16'hFFFF, 16'hFFFF);
    repeat (7) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async rst cmd_ready", {31'h0, bus.cmd_ready}, 1);
    chk("async rst busy", {31'h0, busy}, 0);
    chk("async rst rsp_valid", {31'h0, bus.rsp_valid}, 0);
    chk("async rst outputs", {bus.rsp_hi, bus.rsp_lo}, 0);
    chk("async rst flags/err", {27'h0, bus.rsp_flags, bus.rsp_err}, 0);
    @(negedge clk) rst_n = 1'b1;
    send("add after rst", 4'b0000, 16'h0002, 16'h0003, 16'h0005, 16'h0, 4'b0000, 1'b0, 1);
    q2.push_back('{16'h0, 16'h0, 4'b0000, 1'b1, "mul disabled"});
    @(negedge clk);
    bus2.cmd_valid = 1'b1; bus2.cmd_op = 4'b1000; bus2.cmd_a = 16'h0003; bus2.cmd_b = 16'h0005;
    @(posedge clk);
    #1 bus2.cmd_valid = 1'b0;
    @(posedge clk);
    #1 chk("mul disabled latency", {31'h0, bus2.rsp_valid}, 1);
    repeat (4) @(posedge clk);
    #1 chk("scoreboard drained", q.size() + q2.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
